// File: rtl/bit_serial_matrix_multiply_specific_pkg.sv
// Shared types and constants for the bit-serial Gram-matrix (M*M^T) engine.
// The index table maps each upper-triangle output slot to its (row, col) pair.
package bit_serial_matrix_multiply_specific_pkg;

  localparam int W      = 32;
  localparam int N_ROWS = 5;
  localparam int N_COLS = 2;
  localparam int N_VALS = N_ROWS * N_COLS;
  localparam int N_OUT  = 15;
  localparam int CNT_W  = 6;

  typedef logic [W-1:0]              elem_t;
  typedef elem_t [N_VALS-1:0]        vals_t;
  typedef elem_t [N_OUT-1:0]         res_t;
  typedef logic [CNT_W-1:0]          cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OUT_ROW [N_OUT] = '{
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd1, 3'd1, 3'd1, 3'd1,
    3'd2, 3'd2, 3'd2,
    3'd3, 3'd3,
    3'd4
  };

  localparam logic [2:0] OUT_COL [N_OUT] = '{
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd1, 3'd2, 3'd3, 3'd4,
    3'd2, 3'd3, 3'd4,
    3'd3, 3'd4,
    3'd4
  };

  localparam cnt_t LAST_BIT = 6'd31;

endpackage

// File: rtl/bit_serial_matrix_multiply_specific_serial_dot.sv
// Two-term bit-serial multiply-accumulate: each step adds the shifted
// multiplicands whose corresponding multiplier bit is set.
module bsmm_serial_dot
  import bit_serial_matrix_multiply_specific_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  cnt_t          shamt,
  input  elem_t         mcand0,
  input  elem_t         mcand1,
  input  logic          mbit0,
  input  logic          mbit1,
  output elem_t         acc
);

  elem_t add0_s;
  elem_t add1_s;
  elem_t acc_r;

  // Partial products for the current multiplier bit position.
  always_comb begin
    add0_s = '0;
    add1_s = '0;
    if (mbit0) begin
      add0_s = mcand0 << shamt;
    end else begin
      add0_s = '0;
    end
    if (mbit1) begin
      add1_s = mcand1 << shamt;
    end else begin
      add1_s = '0;
    end
  end

  // Accumulator register; sums wrap modulo 2^W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + add0_s + add1_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/bit_serial_matrix_multiply_specific.sv
// Computes the upper triangle of G = M*M^T for a 5x2 matrix, one multiplier
// bit per cycle across 15 parallel dot-product lanes; fixed 33-cycle latency.
module bit_serial_matrix_multiply_specific #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [9:0][W-1:0]   values,
  output logic [14:0][W-1:0]  result,
  output logic                busy,
  output logic                done
);

  import bit_serial_matrix_multiply_specific_pkg::*;

  state_e              state_r;
  state_e              next_state_s;
  cnt_t                cnt_r;
  logic [9:0][W-1:0]   op_r;
  logic [14:0][W-1:0]  acc_s;
  logic [14:0][W-1:0]  res_r;
  logic                busy_r;
  logic                done_r;
  logic                load_s;
  logic                acc_en_s;
  logic                upd_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_BIT) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    load_s   = 1'b0;
    acc_en_s = 1'b0;
    upd_s    = 1'b0;
    case (state_r)
      ST_IDLE: load_s   = start;
      ST_RUN:  acc_en_s = 1'b1;
      ST_DONE: upd_s    = 1'b1;
      default: begin
        load_s   = 1'b0;
        acc_en_s = 1'b0;
        upd_s    = 1'b0;
      end
    endcase
  end

  // Bit counter doubles as the shift amount for the current step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load_s) begin
      cnt_r <= '0;
    end else if (acc_en_s) begin
      cnt_r <= cnt_r + 6'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Operand snapshot isolates the run from later changes on values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= '0;
    end else if (load_s) begin
      op_r <= values;
    end else begin
      op_r <= op_r;
    end
  end

  for (genvar n = 0; n < N_OUT; n++) begin : g_dot
    localparam int I = int'(OUT_ROW[n]);
    localparam int J = int'(OUT_COL[n]);

    bsmm_serial_dot u_dot (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (load_s),
      .en     (acc_en_s),
      .shamt  (cnt_r),
      .mcand0 (op_r[2*I]),
      .mcand1 (op_r[2*I+1]),
      .mbit0  (op_r[2*J][cnt_r[4:0]]),
      .mbit1  (op_r[2*J+1][cnt_r[4:0]]),
      .acc    (acc_s[n])
    );
  end

  // Result is published only when a run completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= '0;
    end else if (upd_s) begin
      res_r <= acc_s;
    end else begin
      res_r <= res_r;
    end
  end

  // Registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != ST_IDLE);
      done_r <= upd_s;
    end
  end

  assign result = res_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_bit_serial_matrix_multiply_specific.sv
// Randomized self-checking bench for bit_serial_matrix_multiply_specific,
// checked against a plain-arithmetic Gram-matrix model.
module tb_bit_serial_matrix_multiply_specific;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [9:0][31:0]   values;
  logic [14:0][31:0]  result;
  logic               busy;
  logic               done;

  int n_tests;
  int n_fail;

  bit_serial_matrix_multiply_specific #(.W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .values (values),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  // Reference: G[i][j] = M[i][0]*M[j][0] + M[i][1]*M[j][1] mod 2^32.
  function automatic logic [14:0][31:0] model(input logic [9:0][31:0] v);
    logic [14:0][31:0] r;
    int n;
    n = 0;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = i; j < 5; j++) begin
        r[n] = v[2*i] * v[2*j] + v[2*i+1] * v[2*j+1];
        n++;
      end
    end
    return r;
  endfunction

  function automatic logic [9:0][31:0] rand_vals();
    logic [9:0][31:0] v;
    for (int k = 0; k < 10; k++) v[k] = $urandom();
    return v;
  endfunction

  function automatic logic [9:0][31:0] spec_vals();
    logic [9:0][31:0] v;
    v[0] = 32'd1;   v[1] = 32'd3;   v[2] = 32'd5;   v[3] = 32'd19;
    v[4] = 32'd24;  v[5] = 32'd12;  v[6] = 32'd23;  v[7] = 32'd135;
    v[8] = 32'hFFFF_FFE9;           v[9] = 32'd20;
    return v;
  endfunction

  function automatic logic [14:0][31:0] spec_result();
    logic [14:0][31:0] r;
    r[0]  = 32'd10;    r[1]  = 32'd62;    r[2]  = 32'd60;   r[3]  = 32'd428;
    r[4]  = 32'd37;    r[5]  = 32'd386;   r[6]  = 32'd348;  r[7]  = 32'd2680;
    r[8]  = 32'd265;   r[9]  = 32'd720;   r[10] = 32'd2172; r[11] = 32'hFFFF_FEC8;
    r[12] = 32'd18754; r[13] = 32'd2171;  r[14] = 32'd929;
    return r;
  endfunction

  // Drives a one-cycle start; returns just after the accepting edge.
  task automatic launch(input logic [9:0][31:0] v);
    values = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; values = '0;
    #3;
    n_tests++;
    if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done);
    end
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_spec_vector();
    logic [14:0][31:0] prev;
    int bad;
    prev = result;
    bad  = 0;
    launch(spec_vals());
    values = rand_vals();
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1 || done !== 1'b0 || result !== prev) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL spec_during_run: %0d bad cycles want 0", bad); end
    @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL spec_latency: done=%b busy=%b want 1 0", done, busy);
    end
    n_tests++;
    if (result !== spec_result()) begin
      n_fail++; $display("FAIL spec_result: got %h want %h", result, spec_result());
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b0 || result !== spec_result()) begin
      n_fail++; $display("FAIL spec_hold: done=%b got %h want done=0", done, result);
    end
  endtask

  task automatic test_zero_one();
    logic [9:0][31:0] v;
    logic [14:0][31:0] e;
    v = '0;
    launch(v);
    wait_edges(33);
    n_tests++;
    if (done !== 1'b1 || result !== '0) begin
      n_fail++; $display("FAIL zeros: done=%b got %h want 0", done, result);
    end
    for (int k = 0; k < 10; k++) v[k] = 32'd1;
    for (int k = 0; k < 15; k++) e[k] = 32'd2;
    launch(v);
    wait_edges(33);
    n_tests++;
    if (done !== 1'b1 || result !== e) begin
      n_fail++; $display("FAIL ones: done=%b got %h want %h", done, result, e);
    end
  endtask

  task automatic test_wrap();
    logic [9:0][31:0] v;
    v = '0; v[0] = 32'h0001_0000; v[1] = 32'h0001_0000;
    launch(v);
    wait_edges(33);
    n_tests++;
    if (done !== 1'b1 || result[0] !== 32'd0) begin
      n_fail++; $display("FAIL wrap_zero: done=%b got %h want 0", done, result[0]);
    end
    v = '0; v[0] = 32'hFFFF_FFFF;
    launch(v);
    wait_edges(33);
    n_tests++;
    if (done !== 1'b1 || result[0] !== 32'd1) begin
      n_fail++; $display("FAIL wrap_one: done=%b got %h want 1", done, result[0]);
    end
  endtask

  task automatic test_ignore_start();
    launch(spec_vals());
    wait_edges(9);
    values = rand_vals();
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    wait_edges(23);
    n_tests++;
    if (done !== 1'b1 || result !== spec_result()) begin
      n_fail++; $display("FAIL ignore_start: done=%b got %h want %h", done, result, spec_result());
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL ignore_no_restart: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_start_held();
    logic [9:0][31:0] v;
    v = rand_vals();
    values = v;
    start  = 1'b1;
    wait_edges(34);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== model(v)) begin
      n_fail++; $display("FAIL held_first: done=%b busy=%b got %h want %h", done, busy, result, model(v));
    end
    wait_edges(1);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL held_restart: busy=%b done=%b want 1 0", busy, done);
    end
    start = 1'b0;
    wait_edges(33);
    n_tests++;
    if (done !== 1'b1 || result !== model(v)) begin
      n_fail++; $display("FAIL held_second: done=%b got %h want %h", done, result, model(v));
    end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    seen_done = 0;
    launch(rand_vals());
    wait_edges(14);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_immediate: busy=%b done=%b got %h want 0", busy, done, result);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) seen_done++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    n_tests++;
    if (seen_done != 0) begin n_fail++; $display("FAIL abort_no_done: %0d bad cycles want 0", seen_done); end
    launch(spec_vals());
    wait_edges(33);
    n_tests++;
    if (done !== 1'b1 || result !== spec_result()) begin
      n_fail++; $display("FAIL abort_rerun: done=%b got %h want %h", done, result, spec_result());
    end
  endtask

  task automatic test_random();
    logic [9:0][31:0] v;
    for (int r = 0; r < 8; r++) begin
      v = rand_vals();
      if (r == 0) for (int k = 0; k < 10; k++) v[k] = 32'h8000_0000 >> (k % 2);
      launch(v);
      wait_edges(33);
      n_tests++;
      if (done !== 1'b1 || result !== model(v)) begin
        n_fail++; $display("FAIL random_%0d: done=%b got %h want %h", r, done, result, model(v));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0][31:0] va;
    logic [9:0][31:0] vb;
    int bad;
    va = rand_vals();
    vb = rand_vals();
    bad = 0;
    launch(va);
    wait_edges(33);
    n_tests++;
    if (done !== 1'b1 || result !== model(va)) begin
      n_fail++; $display("FAIL b2b_first: done=%b got %h want %h", done, result, model(va));
    end
    launch(vb);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
    end
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (result !== model(va) || done !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_stable: %0d bad cycles want 0", bad); end
    wait_edges(1);
    n_tests++;
    if (done !== 1'b1 || result !== model(vb)) begin
      n_fail++; $display("FAIL b2b_second: done=%b got %h want %h", done, result, model(vb));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_spec_vector();
    test_zero_one();
    test_wrap();
    test_ignore_start();
    test_start_held();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
